bitmap_blit_ctrl: RTL and testbench

//  Sequencer for the 1-bpp bitmap ROM (17-bit address, 1-bit data, 1-cycle registered read).

---
 rtl/bitmap_blit_ctrl_pkg.sv | 19 +
 rtl/bitmap_blit_ctrl_if.sv | 29 ++
 rtl/bitmap_blit_ctrl_skid_buf.sv | 61 ++++++
 rtl/bitmap_blit_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_bitmap_blit_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bitmap_blit_ctrl_pkg.sv
// Shared definitions for the bitmap blitter: FSM state encoding, RGB565 colour constants and the default ROM row pitch.
package bitmap_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } blit_state_e;

    localparam logic [15:0] RGB565_BLACK = 16'h0000;
    localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
    localparam logic [15:0] RGB565_RED   = 16'hF800;
    localparam logic [15:0] RGB565_GREEN = 16'h07E0;
    localparam logic [15:0] RGB565_BLUE  = 16'h001F;

    localparam int DEFAULT_STRIDE = 480;

endpackage

// File: rtl/bitmap_blit_ctrl_if.sv
// Pixel stream from the blitter to the LCD writer (valid/ready).
// With BITMAP_TRANSP_EN defined the stream also carries a per-pixel write enable.
interface bitmap_blit_ctrl_if #(
    parameter int PIX_W = 16
);
    logic             pix_valid;
    logic [PIX_W-1:0] pix_data;
    logic             pix_last;
    logic             pix_ready;
`ifdef BITMAP_TRANSP_EN
    logic             pix_we;
`endif

    modport master (
        input  pix_ready,
        output pix_valid, pix_data, pix_last
`ifdef BITMAP_TRANSP_EN
        , output pix_we
`endif
    );

    modport slave (
        output pix_ready,
        input  pix_valid, pix_data, pix_last
`ifdef BITMAP_TRANSP_EN
        , input pix_we
`endif
    );
endinterface

// File: rtl/bitmap_blit_ctrl_skid_buf.sv
// Two-entry FIFO holding expanded pixels between the ROM read and the pixel sink.
// The head entry never changes while it is valid and not popped.
module bitmap_skid_buf #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] head,
    output logic [1:0]   count
);
    logic [W-1:0] entry0_q, entry0_d;
    logic [W-1:0] entry1_q, entry1_d;
    logic [1:0]   count_q, count_d;

    // The issuer never pushes into a full buffer unless it also pops
    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) entry0_d = push_data;
                else                 entry1_d = push_data;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                entry0_d = entry1_q;
                count_d  = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    entry0_d = push_data;
                end else begin
                    entry0_d = entry1_q;
                    entry1_d = push_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= '0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
        end
    end

    assign valid = (count_q != 2'd0);
    assign head  = entry0_q;
    assign count = count_q;
endmodule

// File: rtl/bitmap_blit_ctrl.sv
// Walks a rectangle of the 1-bpp bitmap ROM and streams RGB565 pixels to the LCD writer.
// Define BITMAP_TRANSP_EN to add transp_i and a per-pixel write enable on the stream.
module bitmap_blit_ctrl
    import bitmap_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int IMG_STRIDE = DEFAULT_STRIDE,
    parameter int COORD_W    = 9,
    parameter int PIX_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [COORD_W-1:0]    x0_i,
    input  logic [COORD_W-1:0]    y0_i,
    input  logic [COORD_W-1:0]    w_i,
    input  logic [COORD_W-1:0]    h_i,
    input  logic [PIX_W-1:0]      fg_i,
    input  logic [PIX_W-1:0]      bg_i,
`ifdef BITMAP_TRANSP_EN
    input  logic                  transp_i,
`endif
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic                  rom_data_i,
    bitmap_blit_ctrl_if.master    pix
);
`ifdef BITMAP_TRANSP_EN
    localparam int BUF_W = PIX_W + 2;
`else
    localparam int BUF_W = PIX_W + 1;
`endif
    localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(IMG_STRIDE);

    blit_state_e           state_q, state_d;
    logic [COORD_W-1:0]    w_q, w_d, h_q, h_d, col_q, col_d, row_q, row_d;
    logic [ADDR_WIDTH-1:0] row_base_q, row_base_d, rom_addr_q, rom_addr_d;
    logic [PIX_W-1:0]      fg_q, fg_d, bg_q, bg_d;
    logic                  inflight_q, inflight_d, inflight_last_q, inflight_last_d;
    logic                  busy_q, busy_d, done_q, done_d;
`ifdef BITMAP_TRANSP_EN
    logic                  transp_q, transp_d;
`endif

    logic [ADDR_WIDTH-1:0] cur_base;
    logic [COORD_W-1:0]    cur_col, cur_row, cur_w, cur_h;
    logic                  issue, issue_last, pop, buf_valid;
    logic [1:0]            buf_count;
    logic [2:0]            occupancy;
    logic [BUF_W-1:0]      buf_head, push_entry;

    assign pop       = buf_valid & pix.pix_ready;
    assign occupancy = 3'(buf_count) + 3'(inflight_q) - 3'(pop);

    // In IDLE the first address comes straight from the request so the ROM read starts in the start cycle
    always_comb begin
        cur_base = row_base_q;
        cur_col  = col_q;
        cur_row  = row_q;
        cur_w    = w_q;
        cur_h    = h_q;
        if (state_q == IDLE) begin
            cur_base = ADDR_WIDTH'(y0_i) * STRIDE + ADDR_WIDTH'(x0_i);
            cur_col  = '0;
            cur_row  = '0;
            cur_w    = w_i;
            cur_h    = h_i;
        end
        issue_last = (cur_col == cur_w - COORD_W'(1)) && (cur_row == cur_h - COORD_W'(1));
        issue = (occupancy < 3'd2) &&
                ((state_q == RUN) ||
                 ((state_q == IDLE) && start_i && (w_i != '0) && (h_i != '0)));
    end

    always_comb begin
        state_d         = state_q;
        w_d             = w_q;
        h_d             = h_q;
        col_d           = col_q;
        row_d           = row_q;
        row_base_d      = row_base_q;
        rom_addr_d      = rom_addr_q;
        fg_d            = fg_q;
        bg_d            = bg_q;
        inflight_d      = issue;
        inflight_last_d = inflight_last_q;
`ifdef BITMAP_TRANSP_EN
        transp_d        = transp_q;
`endif
        if (issue) begin
            rom_addr_d      = cur_base + ADDR_WIDTH'(cur_col);
            inflight_last_d = issue_last;
            if (cur_col == cur_w - COORD_W'(1)) begin
                col_d      = '0;
                row_d      = cur_row + COORD_W'(1);
                row_base_d = cur_base + STRIDE;
            end else begin
                col_d      = cur_col + COORD_W'(1);
                row_d      = cur_row;
                row_base_d = cur_base;
            end
        end
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    w_d  = w_i;
                    h_d  = h_i;
                    fg_d = fg_i;
                    bg_d = bg_i;
`ifdef BITMAP_TRANSP_EN
                    transp_d = transp_i;
`endif
                    if ((w_i == '0) || (h_i == '0)) state_d = DONE;
                    else if (issue_last)             state_d = DRAIN;
                    else                             state_d = RUN;
                end
            end
            RUN:     if (issue && issue_last) state_d = DRAIN;
            DRAIN:   if (pop && buf_head[BUF_W-PIX_W-1]) state_d = DONE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            w_q             <= '0;
            h_q             <= '0;
            col_q           <= '0;
            row_q           <= '0;
            row_base_q      <= '0;
            rom_addr_q      <= '0;
            fg_q            <= '0;
            bg_q            <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
`ifdef BITMAP_TRANSP_EN
            transp_q        <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            w_q             <= w_d;
            h_q             <= h_d;
            col_q           <= col_d;
            row_q           <= row_d;
            row_base_q      <= row_base_d;
            rom_addr_q      <= rom_addr_d;
            fg_q            <= fg_d;
            bg_q            <= bg_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
`ifdef BITMAP_TRANSP_EN
            transp_q        <= transp_d;
`endif
        end
    end

`ifdef BITMAP_TRANSP_EN
    assign push_entry = {(rom_data_i ? fg_q : bg_q), inflight_last_q, (rom_data_i | ~transp_q)};
    assign pix.pix_we = buf_head[0];
`else
    assign push_entry = {(rom_data_i ? fg_q : bg_q), inflight_last_q};
`endif

    bitmap_skid_buf #(.W(BUF_W)) u_skid_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (push_entry),
        .pop       (pop),
        .valid     (buf_valid),
        .head      (buf_head),
        .count     (buf_count)
    );

    assign pix.pix_valid = buf_valid;
    assign pix.pix_data  = buf_head[BUF_W-1 -: PIX_W];
    assign pix.pix_last  = buf_head[BUF_W-PIX_W-1];
    assign rom_addr_o    = rom_addr_d;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
endmodule

// File: tb/tb_bitmap_blit_ctrl.sv
// Directed self-checking bench for bitmap_blit_ctrl with a registered-read ROM model.
// The write-enable vectors only run when BITMAP_TRANSP_EN is defined.
module tb_bitmap_blit_ctrl;
    import bitmap_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  x0 = '0, y0 = '0, w = '0, h = '0;
    logic [15:0] fg = '0, bg = '0;
    logic        busy, done, romData;
    logic [16:0] romAddr;
`ifdef BITMAP_TRANSP_EN
    logic        transp = 1'b0;
    bit          weQ[$];
`endif

    logic        romMem [0:2047];
    int          checkCount = 0;
    int          errorCount = 0;
    int          doneCount = 0;
    int          validSeen = 0;
    logic [15:0] pixQ[$];
    bit          lastQ[$];
    logic [16:0] addrQ[$];
    logic [16:0] prevAddr = '0;
    bit          holdPending = 1'b0;
    logic [15:0] heldData;
    logic        heldLast;

    bitmap_blit_ctrl_if #(.PIX_W(16)) pixIf ();

    bitmap_blit_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .x0_i       (x0),
        .y0_i       (y0),
        .w_i        (w),
        .h_i        (h),
        .fg_i       (fg),
        .bg_i       (bg),
`ifdef BITMAP_TRANSP_EN
        .transp_i   (transp),
`endif
        .busy_o     (busy),
        .done_o     (done),
        .rom_addr_o (romAddr),
        .rom_data_i (romData),
        .pix        (pixIf.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) romData <= romMem[romAddr[10:0]];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Observes the stream on the falling edge, where inputs and outputs are settled for the next handshake
    always @(negedge clk) begin
        if (rst) begin
            holdPending = 1'b0;
        end else begin
            if (holdPending) begin
                checkOutput("hold_valid", 32'(pixIf.pix_valid), 32'd1);
                checkOutput("hold_data", 32'(pixIf.pix_data), 32'(heldData));
                checkOutput("hold_last", 32'(pixIf.pix_last), 32'(heldLast));
            end
            holdPending = pixIf.pix_valid && !pixIf.pix_ready;
            heldData    = pixIf.pix_data;
            heldLast    = pixIf.pix_last;
            if (pixIf.pix_valid && pixIf.pix_ready) begin
                pixQ.push_back(pixIf.pix_data);
                lastQ.push_back(pixIf.pix_last);
`ifdef BITMAP_TRANSP_EN
                weQ.push_back(pixIf.pix_we);
`endif
            end
            if (pixIf.pix_valid) validSeen++;
            if (done) doneCount++;
            if (romAddr != prevAddr) begin
                addrQ.push_back(romAddr);
                prevAddr = romAddr;
            end
        end
    end

    task automatic clearLogs();
        pixQ.delete();
        lastQ.delete();
        addrQ.delete();
`ifdef BITMAP_TRANSP_EN
        weQ.delete();
`endif
        prevAddr  = romAddr;
        validSeen = 0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        pixIf.pix_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clearLogs();
    endtask

    // Pulses start for one cycle; returns 1 ns after the edge that sampled it
    task automatic applyStimulus(input int ax0, input int ay0, input int aw, input int ah,
                                 input logic [15:0] afg, input logic [15:0] abg);
        x0 = 9'(ax0); y0 = 9'(ay0); w = 9'(aw); h = 9'(ah);
        fg = afg; bg = abg;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic waitDone(input int base, input int budget, input bit toggle);
        logic [3:0] pat;
        pat = 4'b1001;
        for (int k = 0; k < budget; k++) begin
            if (doneCount > base) break;
            @(posedge clk);
            #1 pixIf.pix_ready = toggle ? pat[k % 4] : 1'b1;
        end
        pixIf.pix_ready = 1'b1;
        checkOutput("done_seen", 32'(doneCount > base), 32'd1);
        repeat (3) @(posedge clk);
        #1 checkOutput("done_once", 32'(doneCount - base), 32'd1);
    endtask

    task automatic checkPixels(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                               input logic [15:0] e2, input logic [15:0] e3);
        logic [15:0] exp4 [4];
        exp4 = '{e0, e1, e2, e3};
        checkOutput({tag, "_count"}, 32'(pixQ.size()), 32'd4);
        for (int i = 0; i < 4 && i < pixQ.size(); i++) begin
            checkOutput($sformatf("%s_data%0d", tag, i), 32'(pixQ[i]), 32'(exp4[i]));
            checkOutput($sformatf("%s_last%0d", tag, i), 32'(lastQ[i]), 32'(i == 3));
        end
    endtask

    initial begin
        int base;
        pixIf.pix_ready = 1'b1;
        for (int i = 0; i < 2048; i++) romMem[i] = 1'b0;
        romMem[0] = 1'b1; romMem[1] = 1'b0; romMem[2] = 1'b1; romMem[3] = 1'b1;
        romMem[482] = 1'b1; romMem[483] = 1'b0; romMem[962] = 1'b0; romMem[963] = 1'b1;

        $display("[TB] reset values");
        doReset();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_valid", 32'(pixIf.pix_valid), 32'd0);
        checkOutput("rst_last", 32'(pixIf.pix_last), 32'd0);
        checkOutput("rst_data", 32'(pixIf.pix_data), 32'd0);
        checkOutput("rst_addr", 32'(romAddr), 32'd0);

        $display("[TB] 4x1 strip at origin");
        base = doneCount;
        applyStimulus(0, 0, 4, 1, RGB565_RED, RGB565_BLUE);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        checkOutput("t1_valid_c1", 32'(pixIf.pix_valid), 32'd0);
        @(posedge clk);
        #1 checkOutput("t1_valid_c2", 32'(pixIf.pix_valid), 32'd1);
        checkOutput("t1_first_data", 32'(pixIf.pix_data), 32'(RGB565_RED));
        waitDone(base, 60, 1'b0);
        checkPixels("t1", RGB565_RED, RGB565_BLUE, RGB565_RED, RGB565_RED);
        checkOutput("t1_idle", 32'(busy), 32'd0);

        $display("[TB] 2x2 at (2,1)");
        doReset();
        base = doneCount;
        applyStimulus(2, 1, 2, 2, RGB565_GREEN, RGB565_WHITE);
        waitDone(base, 60, 1'b0);
        checkOutput("t2_addr_count", 32'(addrQ.size()), 32'd4);
        if (addrQ.size() == 4) begin
            checkOutput("t2_addr0", 32'(addrQ[0]), 32'd482);
            checkOutput("t2_addr1", 32'(addrQ[1]), 32'd483);
            checkOutput("t2_addr2", 32'(addrQ[2]), 32'd962);
            checkOutput("t2_addr3", 32'(addrQ[3]), 32'd963);
        end
        checkPixels("t2", RGB565_GREEN, RGB565_WHITE, RGB565_WHITE, RGB565_GREEN);

        $display("[TB] 4x1 strip with ready toggling");
        doReset();
        base = doneCount;
        applyStimulus(0, 0, 4, 1, RGB565_RED, RGB565_BLUE);
        waitDone(base, 80, 1'b1);
        checkPixels("t3", RGB565_RED, RGB565_BLUE, RGB565_RED, RGB565_RED);

        $display("[TB] zero-width request");
        doReset();
        base = doneCount;
        applyStimulus(3, 3, 0, 5, RGB565_RED, RGB565_BLUE);
        checkOutput("t4_busy_c1", 32'(busy), 32'd1);
        checkOutput("t4_done_c1", 32'(done), 32'd0);
        @(posedge clk);
        #1 checkOutput("t4_done_c2", 32'(done), 32'd1);
        @(posedge clk);
        #1 checkOutput("t4_done_c3", 32'(done), 32'd0);
        checkOutput("t4_busy_c3", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1 checkOutput("t4_done_once", 32'(doneCount - base), 32'd1);
        checkOutput("t4_no_valid", 32'(validSeen), 32'd0);
        checkOutput("t4_no_addr", 32'(addrQ.size()), 32'd0);

        $display("[TB] reset in the middle of a 4x2 rectangle");
        doReset();
        base = doneCount;
        applyStimulus(0, 0, 4, 2, RGB565_RED, RGB565_BLUE);
        for (int k = 0; k < 50; k++) begin
            if (pixQ.size() >= 3) break;
            @(posedge clk);
            #1;
        end
        checkOutput("t5_three_px", 32'(pixQ.size() >= 3), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 checkOutput("t5_valid", 32'(pixIf.pix_valid), 32'd0);
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_done", 32'(done), 32'd0);
        checkOutput("t5_addr", 32'(romAddr), 32'd0);
        checkOutput("t5_data", 32'(pixIf.pix_data), 32'd0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1 checkOutput("t5_no_done", 32'(doneCount - base), 32'd0);
        clearLogs();
        applyStimulus(0, 0, 4, 1, RGB565_RED, RGB565_BLUE);
        waitDone(base, 60, 1'b0);
        checkPixels("t5", RGB565_RED, RGB565_BLUE, RGB565_RED, RGB565_RED);

`ifdef BITMAP_TRANSP_EN
        $display("[TB] transparent background");
        doReset();
        base = doneCount;
        transp = 1'b1;
        applyStimulus(0, 0, 2, 1, RGB565_RED, RGB565_BLUE);
        transp = 1'b0;
        waitDone(base, 60, 1'b0);
        checkOutput("t6_count", 32'(weQ.size()), 32'd2);
        if (weQ.size() == 2) begin
            checkOutput("t6_we0", 32'(weQ[0]), 32'd1);
            checkOutput("t6_we1", 32'(weQ[1]), 32'd0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errorCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
